// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM gate-driver slice.
// Holds the gate FSM state encoding, the default timing constants and the
// duty-word width, which the upstream power controller shares.
package pwm_pkg;

    // Width of the duty word exchanged with the power controller.
    localparam int DUTY_W = 7;

    // Default timing: PWM period = 128 * PRESC clk cycles, dead time in clk cycles.
    localparam int                PRESC_DEF    = 8;
    localparam int                DEAD_T_DEF   = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX_DEF = 7'd120;

    // Gate FSM states.
    typedef enum logic [2:0] {
        S_OFF   = 3'd0,
        S_LO    = 3'd1,
        S_DT_LH = 3'd2,
        S_HI    = 3'd3,
        S_DT_HL = 3'd4
    } gate_state_e;

    // Upper clamp applied when a new duty word is accepted. Keeping duty
    // below full scale guarantees some low-side on-time every period,
    // which the bootstrap supply needs to recharge.
    function automatic logic [DUTY_W-1:0] clamp_duty(
        input logic [DUTY_W-1:0] req,
        input logic [DUTY_W-1:0] max_d
    );
        return (req > max_d) ? max_d : req;
    endfunction

endpackage

// File: rtl/pwm_gate_driver_if.sv
// Controller-to-gate-driver connection.
//   duty          : requested duty word (1/128 steps)
//   en            : run enable
//   fault         : synchronous fault, active high
//   fault_clr     : single-cycle fault acknowledge
//   pwm_hi/pwm_lo : complementary gate drives
//   period_start  : one-clk pulse at the start of each PWM period
//   fault_latched : sticky fault flag
//   duty_applied  : clamped duty in effect for the current period
// master = power controller side, slave = gate driver side.
interface pwm_gate_driver_if;
    import pwm_pkg::*;

    logic              en;
    logic [DUTY_W-1:0] duty;
    logic              fault;
    logic              fault_clr;
    logic              pwm_hi;
    logic              pwm_lo;
    logic              period_start;
    logic              fault_latched;
    logic [DUTY_W-1:0] duty_applied;

    modport master (
        output en, duty, fault, fault_clr,
        input  pwm_hi, pwm_lo, period_start, fault_latched, duty_applied
    );

    modport slave (
        input  en, duty, fault, fault_clr,
        output pwm_hi, pwm_lo, period_start, fault_latched, duty_applied
    );

endinterface

// File: rtl/pwm_deadtime.sv
// Gate FSM with dead-time insertion for a complementary half-bridge.
//   clk, reset    : clock, asynchronous active-high reset
//   en            : run enable; low forces both gates off on the next clk
//   fault         : raw fault, forces both gates off on the next clk
//   fault_latched : sticky fault flag; holds the gates off until cleared
//   period_start  : restart point when leaving S_OFF
//   d             : high-side demand for the current counter position
//   pwm_hi/pwm_lo : registered gate drives, never both high
// Gate outputs are decoded from the next state and registered alongside it,
// so each gate is a plain flop and both can never be 1 in the same cycle.
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DEAD_T = DEAD_T_DEF   // must be >= 1 and < PRESC
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic fault,
    input  logic fault_latched,
    input  logic period_start,
    input  logic d,
    output logic pwm_hi,
    output logic pwm_lo
);

    localparam int             DT_W    = (DEAD_T > 1) ? $clog2(DEAD_T) : 1;
    localparam logic [DT_W-1:0] DT_LAST = DT_W'(DEAD_T - 1);

    gate_state_e     state;
    gate_state_e     state_nxt;
    logic [DT_W-1:0] dt_cnt;
    logic            dt_done;
    logic            stay_in_dt;

    // dt_cnt counts 0..DEAD_T-1 while in a dead-time state, so a dead-time
    // state lasts exactly DEAD_T cycles.
    assign dt_done    = (dt_cnt == DT_LAST);
    assign stay_in_dt = (state_nxt == state) &&
                        ((state == S_DT_LH) || (state == S_DT_HL));

    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        if (!en || fault || fault_latched) begin
            state_nxt = S_OFF;
        end else begin
            case (state)
                S_OFF:   if (period_start) state_nxt = S_DT_HL;
                S_LO:    if (d)            state_nxt = S_DT_LH;
                S_DT_LH: if (dt_done)      state_nxt = d ? S_HI : S_LO;
                S_HI:    if (!d)           state_nxt = S_DT_HL;
                S_DT_HL: if (dt_done)      state_nxt = d ? S_HI : S_LO;
                default:                   state_nxt = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_OFF;
            dt_cnt <= '0;
            pwm_hi <= 1'b0;
            pwm_lo <= 1'b0;
        end else begin
            state  <= state_nxt;
            dt_cnt <= stay_in_dt ? dt_cnt + 1'b1 : '0;
            pwm_hi <= (state_nxt == S_HI);
            pwm_lo <= (state_nxt == S_LO);
        end
    end

endmodule

// File: rtl/pwm_gate_driver.sv
// PWM gate driver: turns the controller's duty word into a complementary
// half-bridge drive with fixed dead time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : pwm_gate_driver_if.slave (duty/en/fault/fault_clr in;
//                pwm_hi/pwm_lo/period_start/fault_latched/duty_applied out)
// Holds the prescaler, the 7-bit period counter, the shadow duty register
// with its clamp, and the fault latch; the gate FSM lives in pwm_deadtime.
module pwm_gate_driver
    import pwm_pkg::*;
#(
    parameter int                PRESC    = PRESC_DEF,    // clk cycles per counter step
    parameter int                DEAD_T   = DEAD_T_DEF,   // dead time, < PRESC
    parameter logic [DUTY_W-1:0] DUTY_MAX = DUTY_MAX_DEF  // duty clamp
) (
    input  logic             clk,
    input  logic             reset,
    pwm_gate_driver_if.slave bus
);

    localparam int                 PRESC_W    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC - 1);
    localparam logic [DUTY_W-1:0]  CNT_LAST   = '1;

    logic [PRESC_W-1:0] presc;
    logic [DUTY_W-1:0]  cnt;
    logic [DUTY_W-1:0]  duty_shadow;
    logic               period_start_q;
    logic               fault_latched_q;
    logic               tick;
    logic               wrap;
    logic               demand;

    assign tick   = (presc == PRESC_LAST);
    assign wrap   = tick && (cnt == CNT_LAST);
    // High-side demand for this counter position; duty 0 never demands.
    assign demand = (cnt < duty_shadow);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc           <= '0;
            cnt             <= '0;
            duty_shadow     <= '0;
            period_start_q  <= 1'b0;
            fault_latched_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
            presc          <= tick ? '0 : presc + 1'b1;
            period_start_q <= wrap;
            if (tick) begin
                cnt <= cnt + 1'b1;
            end
            // The duty word is only taken at the period boundary, so a
            // mid-period change can never produce a runt pulse.
            if (wrap) begin
                duty_shadow <= clamp_duty(bus.duty, DUTY_MAX);
            end
            // Fault wins over a simultaneous acknowledge.
            fault_latched_q <= bus.fault | (fault_latched_q & ~bus.fault_clr);
        end
    end

    // The raw fault is fed to the FSM as well as the latch so the gates drop
    // on the same edge that sets fault_latched.
    pwm_deadtime #(
        .DEAD_T (DEAD_T)
    ) u_deadtime (
        .clk           (clk),
        .reset         (reset),
        .en            (bus.en),
        .fault         (bus.fault),
        .fault_latched (fault_latched_q),
        .period_start  (period_start_q),
        .d             (demand),
        .pwm_hi        (bus.pwm_hi),
        .pwm_lo        (bus.pwm_lo)
    );

    assign bus.period_start  = period_start_q;
    assign bus.fault_latched = fault_latched_q;
    assign bus.duty_applied  = duty_shadow;

endmodule

// File: doc/pwm_gate_driver.md
Name: pwm_gate_driver

Overview:
Downstream stage of the power-regulation loop. Consumes the 7-bit duty word from the power controller and drives a complementary half-bridge gate pair (pwm_hi / pwm_lo) with fixed dead time. Duty updates are glitch-free at period boundaries, the maximum duty is clamped to guarantee a minimum low-side on-time for the bootstrap supply, and a fault input latches both gates off.

Parameters:
PRESC, 8, clk cycles per PWM counter step; period = 128*PRESC clk cycles
DEAD_T, 4, dead time in clk cycles; both gates off for this many cycles at every hand-over; must be < PRESC
DUTY_MAX, 7'd120, upper clamp applied to the duty input when it is latched

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
en  in  1  run enable; low forces both gates off
duty  in  7  requested duty, in 1/128 steps, from the power controller
fault  in  1  synchronous over-current/over-voltage fault, active high
fault_clr  in  1  single-cycle fault acknowledge
pwm_hi  out  1  high-side gate drive, registered
pwm_lo  out  1  low-side gate drive, registered
period_start  out  1  one-clk pulse on the first clk of each PWM period
fault_latched  out  1  sticky fault flag
duty_applied  out  7  clamped duty in effect for the current period

Behaviour:
- Reset (async, active-high): pwm_hi=0, pwm_lo=0, period_start=0, fault_latched=0, duty_applied=0, prescaler=0, cnt=0, FSM=S_OFF.
- Prescaler: counts 0..PRESC-1 and emits a tick at PRESC-1. The 7-bit cnt advances on each tick and wraps 127->0.
- Period wrap (cnt 127->0 tick): period_start pulses for 1 clk. The shadow duty register latches min(duty, DUTY_MAX), and duty_applied updates the same cycle. Duty changes mid-period have no effect until the next wrap.
- Demand: d = (cnt < duty_applied). duty_applied=0 gives no high-side time.
- Gate FSM, states S_OFF, S_LO, S_DT_LH, S_HI, S_DT_HL; outputs registered from the next state:
  - S_OFF: both gates 0. Entered when en=0 or fault_latched=1. Exits to S_DT_HL at the next period_start once en=1 and fault_latched=0.
  - S_LO: lo=1, hi=0. Goes to S_DT_LH when d=1.
  - S_DT_LH: both gates 0 and a dead-time counter runs. After DEAD_T cycles it goes to S_HI if d=1, else to S_LO.
  - S_HI: hi=1, lo=0. Goes to S_DT_HL when d=0.
  - S_DT_HL: both gates 0. After DEAD_T cycles it goes to S_LO if d=0, else to S_HI.
- Invariant: pwm_hi & pwm_lo is never 1, in any cycle, including around reset and fault.
- Timing per period for duty D with 0<D<=DUTY_MAX: hi on for D*PRESC-DEAD_T clks, lo on for (128-D)*PRESC-DEAD_T clks.
- Fault handling:
  - fault=1 in cycle N gives pwm_hi=pwm_lo=0 and fault_latched=1 in cycle N+1, and the FSM goes to S_OFF.
  - fault_clr clears fault_latched only when fault=0 in the same cycle. If fault and fault_clr are asserted together, fault wins.
  - Restart follows the S_OFF exit rule.
- en deassert mid-period: both gates go 0 on the next clk. cnt and the prescaler keep running so the period phase is preserved.
- Reset mid-operation: outputs drop immediately (async); normal operation resumes from S_OFF.

Decomposition:
- Shared package pwm_pkg holds the FSM state enum (3-bit), the default PRESC/DEAD_T/DUTY_MAX constants, and the 7-bit duty width constant, which is shared with the power controller.
- One sub-module, pwm_deadtime: the gate FSM plus the dead-time counter, taking d/en/fault_latched/period_start and producing pwm_hi/pwm_lo.
- The top level holds the prescaler, cnt, shadow duty, clamp and fault latch.

Test Plan:
- Defaults, duty=64, en=1 -> period 1024 clks; hi 508 clks, lo 508 clks, two 4-clk both-off gaps; period_start every 1024 clks.
- duty changes 64->32 at cnt=10 -> current period keeps hi=508; next period hi=252, lo=764; duty_applied updates exactly on period_start.
- duty=0 -> pwm_hi never asserts; pwm_lo high continuously after the initial 4-clk dead time. duty=127 -> duty_applied=120, hi=956, lo=60.
- fault pulse during S_HI -> both gates 0 next clk, fault_latched=1. fault_clr while fault=1 -> still latched. fault_clr after fault=0 -> cleared; gates resume at next period_start via 4-clk dead time.
- Assert reset during S_HI -> pwm_hi=0 the same cycle (async), all outputs at reset values. Release -> restart at first period_start.
- Random duty/en/fault for 1e6 clks -> assertion that pwm_hi & pwm_lo is never 1, and every hi<->lo transition is separated by ≥DEAD_T both-off cycles.
